// File: rtl/apb_gpu_master.sv
// APB write initiator feeding the GPU command register.
// Buffers {opcode, parameters} commands and issues one APB write each.
module apb_gpu_master #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] GPU_ADDR   = 32'h0000_0000,
   parameter int unsigned MAX_WAIT   = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [3:0]                    opcode_i,
   input  logic [24:0]                   parameters_i,
   output logic [31:0]                   pAddr_o,
   output logic [31:0]                   pDataWrite_o,
   output logic                          pSel_o,
   output logic                          pEnable_o,
   output logic                          pWrite_o,
   input  logic                          pReady_i,
   output logic                          busy_o,
   output logic                          err_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
   localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

   state_e        state_q, state_d;
   logic [28:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [CW-1:0] count_q;
   logic [WW-1:0] wait_q, wait_d;
   logic          push, pop, abort;
   logic [28:0]   head;

   logic          psel_q, psel_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [31:0]   paddr_q, paddr_d;
   logic [31:0]   pdata_q, pdata_d;
   logic          err_q, err_d;

   assign cmd_ready_o = (count_q != FULL);
   assign push        = cmd_valid_i & cmd_ready_o;
   assign rd_nxt      = rd_ptr_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      pop     = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) state_d = SETUP;
         end
         SETUP: begin
            state_d = ACCESS;
            wait_d  = '0;
         end
         ACCESS: begin
            if (pReady_i) begin
               pop     = 1'b1;
               state_d = (count_q > CW'(1)) ? SETUP : IDLE;
            end else if (wait_q == WLAST) begin
               pop     = 1'b1;
               abort   = 1'b1;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A back-to-back SETUP must present the entry behind the one being popped.
   always_comb begin
      head      = pop ? mem_q[rd_nxt] : mem_q[rd_ptr_q];
      psel_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS);
      pwrite_d  = psel_d;
      paddr_d   = psel_d ? GPU_ADDR : 32'h0;
      err_d     = abort;
      pdata_d   = 32'h0;
      if (state_d == SETUP) begin
         pdata_d = {head[28:25], 3'b000, head[24:0]};
      end else if (state_d == ACCESS) begin
         pdata_d = pdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {opcode_i, parameters_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wait_q    <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 32'h0;
         pdata_q   <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_nxt;
         count_q   <= count_q + CW'(push) - CW'(pop);
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pdata_q   <= pdata_d;
         err_q     <= err_d;
      end
   end

   assign pSel_o       = psel_q;
   assign pEnable_o    = penable_q;
   assign pWrite_o     = pwrite_q;
   assign pAddr_o      = paddr_q;
   assign pDataWrite_o = pdata_q;
   assign err_o        = err_q;
   assign count_o      = count_q;
   assign busy_o       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: doc/apb_gpu_master.md
# apb_gpu_master

APB initiator that feeds the GPU command register. Accepts {opcode, parameters} commands from the host-side command source on a valid/ready handshake, buffers them in a small FIFO, and issues each one as a single APB write transfer (setup phase, then access phase) to the GPU's APB slave port. It is the write-issuing end of the same APB link the GPU slave decodes, and sits between the command generator and the GPU.

## Interface
- FIFO_DEPTH, 4: command FIFO entries (power of two, >= 2)
- GPU_ADDR, 32'h0000_0000: value driven on pAddr_o during every transfer
- MAX_WAIT, 15: access-phase cycles allowed with pReady_i low before abort (>= 1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  FIFO can accept; push = cmd_valid_i & cmd_ready_o at posedge
- opcode_i  in  4  GPU opcode
- parameters_i  in  25  GPU parameters
- pAddr_o  out  32  APB address
- pDataWrite_o  out  32  APB write data
- pSel_o  out  1  APB select
- pEnable_o  out  1  APB enable
- pWrite_o  out  1  APB direction (always write when selected)
- pReady_i  in  1  slave ready; tie high for zero-wait slaves
- busy_o  out  1  FIFO non-empty or transfer in progress
- err_o  out  1  one-cycle pulse on timeout abort
- count_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Word packing: pDataWrite_o[31:28] = opcode, [27:25] = 3'b000, [24:0] = parameters.
- FIFO: synchronous, circular read/write pointers, width 29. cmd_ready_o = (count_o != FIFO_DEPTH), derived from count only; a push while full is refused even if a pop occurs the same edge. Push and pop on the same edge in a non-full, non-empty FIFO leave count unchanged. The head entry is not popped until its transfer completes or aborts.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: pSel_o=pEnable_o=pWrite_o=0, pAddr_o=0, pDataWrite_o=0. If count_o != 0 -> SETUP.
  - SETUP (exactly one cycle): pSel_o=1, pEnable_o=0, pWrite_o=1, pAddr_o=GPU_ADDR, pDataWrite_o=packed head entry. -> ACCESS.
  - ACCESS: pSel_o=1, pEnable_o=1; address/data unchanged from SETUP. On pReady_i=1: pop, then -> SETUP if another entry remains after the pop, else -> IDLE. On wait counter reaching MAX_WAIT with pReady_i still 0: pop (drop command), pulse err_o, -> IDLE.
- Wait counter clears on entering ACCESS and increments each ACCESS cycle with pReady_i=0.
- All APB outputs are registered; address/data/pWrite are stable from SETUP through the final ACCESS cycle.
- busy_o = (state != IDLE) | (count_o != 0).

## Timing
- Reset (rst high at posedge): state=IDLE, FIFO flushed (count_o=0), cmd_ready_o=1, all APB outputs 0, busy_o=0, err_o=0, wait counter 0. Reset mid-transfer aborts it with no err_o pulse; pSel_o/pEnable_o low the cycle after the reset edge.
- Push at edge k into empty idle block: count_o=1 after k; pSel_o=1 after k+1 (SETUP); pEnable_o=1 after k+2 (ACCESS); with pReady_i=1, transfer completes at edge k+3, pop at k+3.
- Zero-wait throughput: one APB write per 2 cycles; back-to-back transfers keep pSel_o high, pEnable_o drops for the SETUP cycle.
- Each wait cycle extends ACCESS by one cycle. Abort: after MAX_WAIT low-ready access cycles, err_o=1 for the single cycle following the abort edge.
- cmd_valid_i may be asserted in any state; pushes are independent of FSM state.

## Test plan
- Reset then single command opcode=4'h9, parameters=25'h1C71FCF, pReady_i=1 -> one transfer, pDataWrite_o=32'h91C71FCF, pSel_o high 2 cycles, pEnable_o high 1 cycle, busy_o low afterward.
- Push all-ones then all-zeros back-to-back -> 32'hF1FFFFFF then 32'h00000000; pSel_o continuously high for 4 cycles; count_o returns to 0.
- Push 5 commands with no pops (pReady_i=0, MAX_WAIT large) -> cmd_ready_o low after 4th push, 5th refused, count_o=4.
- pReady_i held low 3 cycles in ACCESS -> ACCESS lasts 4 cycles, data/address stable throughout, no err_o.
- pReady_i held low, MAX_WAIT=15 -> err_o pulses once after 15 wait cycles, entry dropped, next entry begins SETUP one cycle after IDLE.
- Assert rst during ACCESS with 3 entries queued -> next cycle all APB outputs 0, count_o=0, err_o=0, no further transfers.
